// File: rtl/stepper_step_ctrl.sv
// rtl/stepper_step_ctrl.sv - trapezoidal-ramp move controller driving the stepper phase sequencer
// Optional STEP_CTRL_POSITION_EN adds a signed step position counter output.
module stepper_step_ctrl #(
   parameter int CNT_W     = 16,
   parameter int DIV_W     = 20,
   parameter int MIN_DIV   = 2,
   parameter int START_DIV = 1000,
   parameter int ACC_STEP  = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_cmd_valid,
   output logic             o_cmd_ready,
   input  logic [CNT_W-1:0] i_cmd_steps,
   input  logic             i_cmd_dir,
   input  logic [DIV_W-1:0] i_cmd_div,
   output logic             o_step,
   output logic             o_dir,
   output logic             o_busy,
   output logic             o_done
`ifdef STEP_CTRL_POSITION_EN
  ,output logic signed [CNT_W+7:0] o_position
`endif
);

   typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, DECEL, DONE} state_t;

   localparam logic [DIV_W-1:0] MIN_C   = DIV_W'(MIN_DIV);
   localparam logic [DIV_W-1:0] START_C = DIV_W'(START_DIV);
   localparam logic [DIV_W-1:0] ACC_C   = DIV_W'(ACC_STEP);

   state_t           state_q, state_d;
   logic [DIV_W-1:0] tgt_q, tgt_d;
   logic [DIV_W-1:0] cur_q, cur_d;
   logic [DIV_W-1:0] timer_q, timer_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] ramp_q, ramp_d;
   logic             dir_q, dir_d;
   logic             step_q, busy_q, done_q, ready_q;

   logic [DIV_W-1:0] tgt_in, cur_in, cur_up, cur_dn;
   logic [DIV_W:0]   up_sum;

   always_comb begin
      tgt_in = (i_cmd_div < MIN_C) ? MIN_C : i_cmd_div;
      cur_in = (tgt_in > START_C) ? tgt_in : START_C;
      // Widened sum so a period near the top of the range cannot wrap.
      up_sum = {1'b0, cur_q} + {1'b0, ACC_C};
      cur_up = (up_sum > {1'b0, START_C}) ? START_C : up_sum[DIV_W-1:0];
      cur_dn = ((cur_q - tgt_q) > ACC_C) ? (cur_q - ACC_C) : tgt_q;
   end

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      cur_d   = cur_q;
      timer_d = timer_q;
      rem_d   = rem_q;
      ramp_d  = ramp_q;
      dir_d   = dir_q;
      case (state_q)
         IDLE: begin
            if (i_cmd_valid) begin
               tgt_d   = tgt_in;
               cur_d   = cur_in;
               timer_d = cur_in;
               rem_d   = i_cmd_steps;
               ramp_d  = '0;
               dir_d   = i_cmd_dir;
               if (i_cmd_steps == '0)
                  state_d = DONE;
               else if (cur_in == tgt_in)
                  state_d = CRUISE;
               else
                  state_d = ACCEL;
            end
         end
         ACCEL, CRUISE, DECEL: begin
            if (timer_q == DIV_W'(1)) begin
               rem_d = rem_q - CNT_W'(1);
               // Decel check outranks accel, which yields triangular short moves.
               if (rem_d == '0) begin
                  state_d = DONE;
               end else if (state_q == DECEL || rem_d <= ramp_q) begin
                  state_d = DECEL;
                  cur_d   = cur_up;
               end else if (state_q == ACCEL) begin
                  ramp_d = ramp_q + CNT_W'(1);
                  cur_d  = cur_dn;
                  if (cur_dn == tgt_q)
                     state_d = CRUISE;
               end
               timer_d = cur_d;
            end else begin
               timer_d = timer_q - DIV_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tgt_q   <= '0;
         cur_q   <= '0;
         timer_q <= '0;
         rem_q   <= '0;
         ramp_q  <= '0;
         dir_q   <= 1'b0;
         step_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         cur_q   <= cur_d;
         timer_q <= timer_d;
         rem_q   <= rem_d;
         ramp_q  <= ramp_d;
         dir_q   <= dir_d;
         // Outputs are registered from the next state so they line up with state_q.
         step_q  <= (state_d == ACCEL || state_d == CRUISE || state_d == DECEL)
                    && (timer_d == DIV_W'(1));
         busy_q  <= (state_d == ACCEL || state_d == CRUISE || state_d == DECEL);
         done_q  <= (state_d == DONE);
         ready_q <= (state_d == IDLE);
      end
   end

   assign o_step      = step_q;
   assign o_dir       = dir_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_cmd_ready = ready_q;

`ifdef STEP_CTRL_POSITION_EN
   logic signed [CNT_W+7:0] pos_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pos_q <= '0;
      else if (step_q)
         pos_q <= dir_q ? pos_q + (CNT_W+8)'(1) : pos_q - (CNT_W+8)'(1);
   end

   assign o_position = pos_q;
`endif

endmodule
